// File: rtl/acc_pkg.sv
// Shared encodings for the BIU read arbiter.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } arb_state_t;

  localparam logic ARB_IMAP = 1'b0;
  localparam logic ARB_WGT  = 1'b1;

  localparam logic [15:0] BEAT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted most recently.
module rr_pick2
  import acc_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_idx_o,
  output logic       gnt_vld_o
);

  // Pick the winner from the request pair and the previous grant.
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = ARB_IMAP;
    if (req_i == 2'b10) begin
      gnt_idx_o = ARB_WGT;
    end else if (req_i == 2'b11) begin
      gnt_idx_o = ~last_i;
    end
  end

endmodule

// File: rtl/biu_arbiter.sv
// Read arbiter between the imap and weight BIUs and the single memory
// read port. One read is outstanding at a time; request and response
// paths are combinational muxes selected by the registered owner.
module biu_arbiter
  import acc_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int QUOTA = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imap_biu2arb_req,
  input  logic [AW-1:0] imap_biu2arb_addr,
  input  logic          imap_biu2arb_vld,
  output logic          imap_biu2arb_rdy,
  output logic [AW-1:0] arb2imap_biu_addr,
  output logic [DW-1:0] arb2imap_biu_data,
  output logic          arb2imap_biu_vld,
  input  logic          arb2imap_biu_rdy,
  input  logic          wgt_biu2arb_req,
  input  logic [AW-1:0] wgt_biu2arb_addr,
  input  logic          wgt_biu2arb_vld,
  output logic          wgt_biu2arb_rdy,
  output logic [AW-1:0] arb2wgt_biu_addr,
  output logic [DW-1:0] arb2wgt_biu_data,
  output logic          arb2wgt_biu_vld,
  input  logic          arb2wgt_biu_rdy,
  output logic [AW-1:0] arb2mem_addr,
  output logic          arb2mem_vld,
  input  logic          arb2mem_rdy,
  input  logic [AW-1:0] mem2arb_addr,
  input  logic [DW-1:0] mem2arb_data,
  input  logic          mem2arb_vld,
  output logic          mem2arb_rdy
);

  arb_state_t  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;

  logic          gnt_idx, gnt_vld;
  logic          own_req, own_vld, own_rsp_rdy, other_req;
  logic [AW-1:0] own_addr;
  logic [16:0]   cnt_inc;
  logic          quota_hit;
  logic          rsp_hs;

  rr_pick2 u_pick (
    .req_i     ({wgt_biu2arb_req, imap_biu2arb_req}),
    .last_i    (last_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Owner-side views of both requesters.
  always_comb begin
    own_req     = (owner_q == ARB_WGT) ? wgt_biu2arb_req  : imap_biu2arb_req;
    own_vld     = (owner_q == ARB_WGT) ? wgt_biu2arb_vld  : imap_biu2arb_vld;
    own_addr    = (owner_q == ARB_WGT) ? wgt_biu2arb_addr : imap_biu2arb_addr;
    own_rsp_rdy = (owner_q == ARB_WGT) ? arb2wgt_biu_rdy  : arb2imap_biu_rdy;
    other_req   = (owner_q == ARB_WGT) ? imap_biu2arb_req : wgt_biu2arb_req;
    cnt_inc     = {1'b0, beat_cnt_q} + 17'd1;
    quota_hit   = (cnt_inc == 17'(QUOTA));
    rsp_hs      = mem2arb_vld & own_rsp_rdy;
  end

  // State register, owner, last grant and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= ARB_IMAP;
      last_q     <= ARB_WGT;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic: grant, issue one beat, wait for its response.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d    = gnt_idx;
          last_d     = gnt_idx;
          beat_cnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (own_vld && arb2mem_rdy) begin
          state_d = WAIT;
        end else if (!own_req && !own_vld) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (rsp_hs) begin
          beat_cnt_d = (beat_cnt_q == BEAT_MAX) ? beat_cnt_q : cnt_inc[15:0];
          if (!own_req || (quota_hit && other_req)) begin
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output muxing: only the owner in the matching state sees handshakes.
  always_comb begin
    imap_biu2arb_rdy  = 1'b0;
    wgt_biu2arb_rdy   = 1'b0;
    arb2imap_biu_addr = '0;
    arb2imap_biu_data = '0;
    arb2imap_biu_vld  = 1'b0;
    arb2wgt_biu_addr  = '0;
    arb2wgt_biu_data  = '0;
    arb2wgt_biu_vld   = 1'b0;
    arb2mem_addr      = '0;
    arb2mem_vld       = 1'b0;
    mem2arb_rdy       = 1'b0;
    case (state_q)
      ISSUE: begin
        arb2mem_addr = own_addr;
        arb2mem_vld  = own_vld;
        if (owner_q == ARB_WGT) wgt_biu2arb_rdy  = arb2mem_rdy;
        else                    imap_biu2arb_rdy = arb2mem_rdy;
      end
      WAIT: begin
        mem2arb_rdy = own_rsp_rdy;
        if (owner_q == ARB_WGT) begin
          arb2wgt_biu_addr = mem2arb_addr;
          arb2wgt_biu_data = mem2arb_data;
          arb2wgt_biu_vld  = mem2arb_vld;
        end else begin
          arb2imap_biu_addr = mem2arb_addr;
          arb2imap_biu_data = mem2arb_data;
          arb2imap_biu_vld  = mem2arb_vld;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_biu_arbiter.sv
// Directed bench for biu_arbiter with QUOTA = 2.
module tb_biu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imap_biu2arb_req = 0, imap_biu2arb_vld = 0, imap_biu2arb_rdy;
  logic [31:0] imap_biu2arb_addr = 0;
  logic [31:0] arb2imap_biu_addr, arb2imap_biu_data;
  logic        arb2imap_biu_vld, arb2imap_biu_rdy = 0;
  logic        wgt_biu2arb_req = 0, wgt_biu2arb_vld = 0, wgt_biu2arb_rdy;
  logic [31:0] wgt_biu2arb_addr = 0;
  logic [31:0] arb2wgt_biu_addr, arb2wgt_biu_data;
  logic        arb2wgt_biu_vld, arb2wgt_biu_rdy = 0;
  logic [31:0] arb2mem_addr;
  logic        arb2mem_vld, arb2mem_rdy = 0;
  logic [31:0] mem2arb_addr = 0, mem2arb_data = 0;
  logic        mem2arb_vld = 0, mem2arb_rdy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ia, wa, hold_addr;
  int imap_done, wgt_done;

  always #5 clk = ~clk;

  biu_arbiter #(.AW(32), .DW(32), .QUOTA(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imap_biu2arb_req(imap_biu2arb_req), .imap_biu2arb_addr(imap_biu2arb_addr),
    .imap_biu2arb_vld(imap_biu2arb_vld), .imap_biu2arb_rdy(imap_biu2arb_rdy),
    .arb2imap_biu_addr(arb2imap_biu_addr), .arb2imap_biu_data(arb2imap_biu_data),
    .arb2imap_biu_vld(arb2imap_biu_vld), .arb2imap_biu_rdy(arb2imap_biu_rdy),
    .wgt_biu2arb_req(wgt_biu2arb_req), .wgt_biu2arb_addr(wgt_biu2arb_addr),
    .wgt_biu2arb_vld(wgt_biu2arb_vld), .wgt_biu2arb_rdy(wgt_biu2arb_rdy),
    .arb2wgt_biu_addr(arb2wgt_biu_addr), .arb2wgt_biu_data(arb2wgt_biu_data),
    .arb2wgt_biu_vld(arb2wgt_biu_vld), .arb2wgt_biu_rdy(arb2wgt_biu_rdy),
    .arb2mem_addr(arb2mem_addr), .arb2mem_vld(arb2mem_vld), .arb2mem_rdy(arb2mem_rdy),
    .mem2arb_addr(mem2arb_addr), .mem2arb_data(mem2arb_data),
    .mem2arb_vld(mem2arb_vld), .mem2arb_rdy(mem2arb_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    logic any;
    any = imap_biu2arb_rdy | (|arb2imap_biu_addr) | (|arb2imap_biu_data) | arb2imap_biu_vld |
          wgt_biu2arb_rdy | (|arb2wgt_biu_addr) | (|arb2wgt_biu_data) | arb2wgt_biu_vld |
          (|arb2mem_addr) | arb2mem_vld | mem2arb_rdy;
    chk(tag, {63'd0, any}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // Called at negedge+1 with the DUT in ISSUE for owner 'who'; runs one
  // beat with a one-cycle memory and leaves the bench one cycle after WAIT.
  task automatic beat(input logic who, input logic last_word);
    logic [31:0] a;
    a = who ? wa : ia;
    chk("iss_vld", {63'd0, arb2mem_vld}, 64'd1);
    chk("iss_addr", {32'd0, arb2mem_addr}, {32'd0, a});
    chk("own_rdy", {63'd0, who ? wgt_biu2arb_rdy : imap_biu2arb_rdy}, 64'd1);
    chk("oth_rdy", {63'd0, who ? imap_biu2arb_rdy : wgt_biu2arb_rdy}, 64'd0);
    step();
    mem2arb_vld  = 1'b1;
    mem2arb_addr = a;
    mem2arb_data = a ^ 32'hA5A5A5A5;
    if (last_word) begin
      if (who) begin wgt_biu2arb_req = 0; wgt_biu2arb_vld = 0; end
      else     begin imap_biu2arb_req = 0; imap_biu2arb_vld = 0; end
    end
    #1;
    chk("rsp_vld",  {63'd0, who ? arb2wgt_biu_vld : arb2imap_biu_vld}, 64'd1);
    chk("rsp_addr", {32'd0, who ? arb2wgt_biu_addr : arb2imap_biu_addr}, {32'd0, a});
    chk("rsp_data", {32'd0, who ? arb2wgt_biu_data : arb2imap_biu_data},
        {32'd0, a ^ 32'hA5A5A5A5});
    chk("oth_vld",  {63'd0, who ? arb2imap_biu_vld : arb2wgt_biu_vld}, 64'd0);
    chk("oth_ad",   {who ? arb2imap_biu_addr : arb2wgt_biu_addr,
                     who ? arb2imap_biu_data : arb2wgt_biu_data}, 64'd0);
    chk("mem_rdy",  {63'd0, mem2arb_rdy}, 64'd1);
    chk("wait_mvld", {63'd0, arb2mem_vld}, 64'd0);
    $display("[TB] beat owner=%0d addr=%08h", who, a);
    step();
    mem2arb_vld = 1'b0;
    if (who) begin wa = wa + 4; wgt_biu2arb_addr = wa; end
    else     begin ia = ia + 4; imap_biu2arb_addr = ia; end
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk_all_zero("rst_outs");
    step();
    rst_n = 1'b1;
    #1;
    chk_all_zero("post_rst_outs");

    // Imap only, 4 words
    ia = 32'h1000; wa = 32'h0;
    imap_biu2arb_addr = ia; imap_biu2arb_req = 1; imap_biu2arb_vld = 1;
    arb2imap_biu_rdy = 1; arb2wgt_biu_rdy = 1; arb2mem_rdy = 1;
    #1;
    chk("grant_lat", {63'd0, arb2mem_vld}, 64'd0);
    step();
    for (int i = 0; i < 4; i++) beat(1'b0, i == 3);
    chk("t1_idle", {63'd0, arb2mem_vld}, 64'd0);
    chk("t1_iaddr", {32'd0, ia}, 64'h1010);

    // Both requesters, QUOTA = 2, 6 words each
    do_reset();
    ia = 32'h2000; wa = 32'h3000;
    imap_biu2arb_addr = ia; wgt_biu2arb_addr = wa;
    imap_biu2arb_req = 1; imap_biu2arb_vld = 1;
    wgt_biu2arb_req = 1; wgt_biu2arb_vld = 1;
    imap_done = 0; wgt_done = 0;
    #1;
    chk("t2_idle0", {63'd0, arb2mem_vld}, 64'd0);
    step();
    for (int i = 0; i < 12; i++) begin
      logic who;
      who = logic'((i / 2) % 2);
      if (who) begin wgt_done++;  beat(1'b1, wgt_done == 6); end
      else     begin imap_done++; beat(1'b0, imap_done == 6); end
      if ((i % 2) == 1 && i < 11) begin
        chk("t2_switch_idle", {63'd0, arb2mem_vld}, 64'd0);
        step();
      end
    end
    chk("t2_end_idle", {63'd0, arb2mem_vld}, 64'd0);

    // Memory not ready for 3 cycles in ISSUE
    ia = 32'h4000; imap_biu2arb_addr = ia;
    imap_biu2arb_req = 1; imap_biu2arb_vld = 1; arb2mem_rdy = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("stall_vld", {63'd0, arb2mem_vld}, 64'd1);
      chk("stall_addr", {32'd0, arb2mem_addr}, 64'h4000);
      chk("stall_rdy", {63'd0, imap_biu2arb_rdy}, 64'd0);
      step();
    end
    arb2mem_rdy = 1;
    #1;
    beat(1'b0, 1'b1);

    // Weight response back-pressured for 2 cycles
    wa = 32'h5000; wgt_biu2arb_addr = wa;
    wgt_biu2arb_req = 1; wgt_biu2arb_vld = 1;
    step();
    chk("bp_iss_rdy", {63'd0, wgt_biu2arb_rdy}, 64'd1);
    step();
    mem2arb_vld = 1; mem2arb_addr = 32'h5000; mem2arb_data = 32'hDEADBEEF;
    arb2wgt_biu_rdy = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_mem_rdy", {63'd0, mem2arb_rdy}, 64'd0);
      chk("bp_vld", {63'd0, arb2wgt_biu_vld}, 64'd1);
      chk("bp_data", {32'd0, arb2wgt_biu_data}, 64'hDEADBEEF);
      step();
    end
    arb2wgt_biu_rdy = 1; wgt_biu2arb_req = 0; wgt_biu2arb_vld = 0;
    #1;
    chk("bp_rel_rdy", {63'd0, mem2arb_rdy}, 64'd1);
    step();
    mem2arb_vld = 0;
    #1;
    chk("bp_idle", {63'd0, arb2mem_vld | wgt_biu2arb_rdy | mem2arb_rdy}, 64'd0);

    // Reset during WAIT of imap beat 3
    ia = 32'h6000; imap_biu2arb_addr = ia;
    imap_biu2arb_req = 1; imap_biu2arb_vld = 1;
    step();
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    step();
    mem2arb_vld = 1; mem2arb_addr = ia; mem2arb_data = ia ^ 32'hA5A5A5A5;
    #1;
    chk("rw_pre_vld", {63'd0, arb2imap_biu_vld}, 64'd1);
    rst_n = 0; imap_biu2arb_req = 0; imap_biu2arb_vld = 0;
    #1;
    chk_all_zero("rw_async");
    step();
    chk_all_zero("rw_hold");
    #2;
    rst_n = 1;
    #1;
    chk("rw_late_rdy", {63'd0, mem2arb_rdy}, 64'd0);
    chk("rw_late_vld", {63'd0, arb2imap_biu_vld}, 64'd0);
    step();
    chk("rw_idle_rdy", {63'd0, mem2arb_rdy | arb2mem_vld}, 64'd0);
    mem2arb_vld = 0;

    // Stray memory response in IDLE
    step();
    mem2arb_vld = 1; mem2arb_addr = 32'h7000; mem2arb_data = 32'h12345678;
    #1;
    chk("stray_rdy", {63'd0, mem2arb_rdy}, 64'd0);
    chk("stray_vld", {62'd0, arb2imap_biu_vld, arb2wgt_biu_vld}, 64'd0);
    step();
    chk("stray_rdy2", {63'd0, mem2arb_rdy}, 64'd0);
    mem2arb_vld = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/biu_arbiter.md
# biu_arbiter

Two-requester read arbiter between the input-feature-map bus interface unit (imap BIU) and the weight bus interface unit (wgt BIU) on one side and the accelerator's single memory read port on the other. It takes word-read requests from both BIUs and issues them one at a time to memory. Each response is returned, with its address, to the BIU that issued the read. It is the direct upstream feeder of the imap BIU's `arb2imap_biu_*` response port.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `QUOTA`, 16, maximum beats served to one owner while the other requester is waiting (1..65535)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `imap_biu2arb_req` in 1: imap BIU wants ownership; held for the whole transfer
- `imap_biu2arb_addr` in AW: imap read address
- `imap_biu2arb_vld` in 1: imap read beat valid
- `imap_biu2arb_rdy` out 1: imap read beat accepted
- `arb2imap_biu_addr` out AW: response address to imap
- `arb2imap_biu_data` out DW: response data to imap
- `arb2imap_biu_vld` out 1: response valid to imap
- `arb2imap_biu_rdy` in 1: imap accepts response
- `wgt_biu2arb_req`, `wgt_biu2arb_addr`, `wgt_biu2arb_vld`, `wgt_biu2arb_rdy`: weight request side, identical to the imap request side
- `arb2wgt_biu_addr`, `arb2wgt_biu_data`, `arb2wgt_biu_vld`, `arb2wgt_biu_rdy`: weight response side, identical to the imap response side
- `arb2mem_addr` out AW: memory read address
- `arb2mem_vld` out 1: memory read request valid
- `arb2mem_rdy` in 1: memory accepts request
- `mem2arb_addr` in AW: address echoed with the read data
- `mem2arb_data` in DW: read data
- `mem2arb_vld` in 1: read data valid
- `mem2arb_rdy` out 1: arbiter accepts read data

## Operation
- Requesters increment their address only on response handshake. The arbiter therefore allows one outstanding read in total.
- Registered state:
  - `state` ∈ {IDLE, ISSUE, WAIT}
  - `owner` (0 = imap, 1 = wgt)
  - `last` (owner most recently granted)
  - `beat_cnt` (16 bit)
- IDLE:
  - If exactly one `req` is high, grant that requester.
  - If both are high, grant the requester that is not `last`.
  - On grant: `owner` ← granted requester, `last` ← granted requester, `beat_cnt` ← 0, go to ISSUE.
- ISSUE:
  - `arb2mem_addr` = owner's addr; `arb2mem_vld` = owner's vld.
  - Owner's `biu2arb_rdy` = `arb2mem_rdy`.
  - On request handshake (vld & rdy), go to WAIT.
  - If the owner's `req` is low with no beat pending, go to IDLE.
- WAIT:
  - The mem response is muxed combinationally to the owner's response port (addr, data, vld).
  - `mem2arb_rdy` = owner's response rdy.
  - On response handshake, `beat_cnt` += 1, then:
    - If the owner's req is low, or (`beat_cnt`+1 == QUOTA and the other req is high), go to IDLE. The re-arbitration in IDLE then hands over, because `last` ≠ the other requester.
    - Otherwise go to ISSUE.
- Outside its own state, each handshake signal is 0. In particular:
  - `biu2arb_rdy` is 0 outside ISSUE-as-owner.
  - `arb2*_biu_vld` is 0 outside WAIT-as-owner.
  - `mem2arb_rdy` is 0 outside WAIT.
- The non-owner's response addr and data outputs are 0.
- `beat_cnt` saturates at 0xFFFF and only matters against QUOTA. A single requester is never preempted.
- A `mem2arb_vld` outside WAIT is a protocol error. It is ignored and not acknowledged.

## Timing
- Reset value of every output: 0. Internal reset: state = IDLE, owner = 0, last = 1, so imap wins the first tie.
- Grant latency: `req` high in IDLE → ISSUE next cycle → `arb2mem_vld` visible in that cycle.
- Request path and response path are purely combinational through the arbiter: zero added latency.
- Minimum beat period with an ideal 1-cycle memory: 2 cycles per word (ISSUE, WAIT). Owner switch adds 1 IDLE cycle.
- `arb2mem_addr` and `arb2mem_vld` must stay stable while `arb2mem_rdy` is low. This holds because the owner cannot change in ISSUE.
- Reset asserted mid-WAIT: all outputs go to 0 immediately (asynchronously). An in-flight memory response after reset is dropped, because `mem2arb_rdy` = 0 in IDLE.
- Simultaneous final response handshake and other requester's `req` rising: the other requester is granted on the cycle after the IDLE cycle.

## Structure
- Shared package `acc_pkg` holds:
  - state encoding typedef `arb_state_t` (IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10)
  - owner constants `ARB_IMAP` = 1'b0, `ARB_WGT` = 1'b1
- One sub-module: `rr_pick2`, the 2-way round-robin picker (inputs: req[1:0], last; output: grant index, grant valid). All other logic lives in `biu_arbiter`.

## Test plan
- Imap only, base 0x1000, 4 words, memory returns data = addr ^ 0xA5A5A5A5 after 1 cycle:
  - memory sees 0x1000, 0x1004, 0x1008, 0x100C
  - imap receives four matching addr/data pairs
  - each beat takes 2 cycles; wgt outputs stay 0
- Both `req` rise in the same cycle after reset, QUOTA = 2, each requester needs 6 words: beat owner sequence is I I W W I I W W I I W W, with one IDLE cycle between owners.
- `arb2mem_rdy` held low 3 cycles in ISSUE: `arb2mem_addr` and `arb2mem_vld` are stable for all 3 cycles; the owner's `rdy` is 0 until the cycle `arb2mem_rdy` is 1.
- `arb2wgt_biu_rdy` low 2 cycles while the response is valid: `mem2arb_rdy` = 0 for those cycles; state stays WAIT; data is forwarded unchanged.
- `rst_n` pulsed low during WAIT of imap beat 3: all outputs are 0 within the reset window; after release the state is IDLE and the late `mem2arb_vld` is not acknowledged.
- Stray `mem2arb_vld` = 1 in IDLE: `mem2arb_rdy` = 0; no requester sees a valid response.
